kbd_matrix_queue: RTL and testbench
===================================

Name: kbd_matrix_queue

Overview:
Parametrised successor to the Ondra keyboard matrix emulator. Converts PS/2 key events into an active-low COLS x ROWS key matrix that the CPU scans one column at a time. New behaviour: a buffered event queue and a minimum hold time per event, so a fast press/release pair is never lost between two CPU scans. Scancode-to-matrix mapping is an external combinational lookup, so one block serves any machine layout.

Parameters:
COLS, 15, number of matrix columns (1..16)
ROWS, 5, number of row lines (1..8)
FIFO_DEPTH, 8, event queue depth; power of two, 2..64
HOLD_CYCLES, 100000, minimum clk cycles each applied event stays in effect before the next event is applied (>=1)
COL_W, derived $clog2(COLS) (min 1); ROW_W, derived $clog2(ROWS) (min 1); LVL_W, derived $clog2(FIFO_DEPTH)+1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
ps2_key  in  11  [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode
column  in  COL_W  column being scanned by CPU
row  out  ROWS  active-low row state of selected column (1 = released)
map_code  out  9  {extended, scancode} presented to external map
map_valid  in  1  combinational: map_code is a matrix key
map_col  in  COL_W  combinational: target column
map_row  in  ROW_W  combinational: target row
fifo_level  out  LVL_W  events queued, 0..FIFO_DEPTH
overflow  out  1  sticky: an event was dropped
busy  out  1  high while queue non-empty or hold timer running

Behaviour:
- One clock, clk; reset synchronous active-high. Reset: all matrix bits 1, FIFO empty, fifo_level 0, overflow 0, busy 0, FSM IDLE, hold counter 0, strobe register loaded with current ps2_key[10] (no spurious event on release of reset).
- Capture: event = ps2_key[10] differs from registered copy. map_code = {ps2_key[8], ps2_key[7:0]} continuously. On event with map_valid=1 and map_col<COLS and map_row<ROWS: push {pressed, map_col, map_row}. Otherwise ignore.
- Push when full: accepted if a pop occurs the same cycle; otherwise dropped and overflow set (cleared only by reset).
- FSM IDLE: if FIFO non-empty, pop head; matrix[col][row] <= ~pressed on the next clock edge (1-cycle latency pop-to-row); load counter HOLD_CYCLES-1; go HOLD.
- FSM HOLD: decrement each cycle; at 0 go IDLE. Next pop occurs no earlier than HOLD_CYCLES cycles after previous pop.
- Multiple PC keys mapped to same matrix bit: last applied event wins.
- row: combinational read of matrix[column]; column >= COLS returns all 1s.
- fifo_level/overflow/busy registered, reflect state after the current edge.
- Reset mid-hold or with queued events: everything cleared, queued events discarded.

Optional Feature:
KBD_REPEAT_FILTER_EN: when defined, a press event whose target bit is already pressed in the matrix and has no pending entry for it (tracked by a COLS*ROWS "pressed-shadow" updated at push time) is discarded before the FIFO, so typematic repeats do not consume queue slots or hold time; overflow not set for filtered events. When undefined, every mapped event is queued.

Test Plan:
- HOLD_CYCLES=4: reset, toggle strobe with code 0x15 pressed, map (col 0,row 0) -> row[0]=0 for column 0 three cycles after strobe toggle; fifo_level 1 then 0; busy high 5 cycles.
- Press then release 0x15 in consecutive cycles -> row bit low exactly 4 cycles, then high; neither event lost.
- FIFO_DEPTH=8: 10 events in 10 consecutive cycles while HOLD active -> 9 accepted (one pop during burst), 1 dropped, overflow=1, fifo_level peaks 8.
- map_valid=0 for code 0x66 -> no push, fifo_level stays 0, row unchanged; column=15 (>=COLS) -> row=5'b11111.
- Assert reset with 3 queued events mid-hold -> next cycle all rows 1, fifo_level 0, busy 0, overflow 0; no event on first cycle after reset despite ps2_key[10]=1.
- With KBD_REPEAT_FILTER_EN: press 0x1C, let apply, send 5 repeat presses -> fifo_level stays 0, then release -> bit returns 1 after one pop.

Source files
------------

// File: rtl/kbd_matrix_queue.sv
// kbd_matrix_queue: turns PS/2 key events into an active-low COLS x ROWS key
// matrix. Mapped events are buffered in a FIFO and applied one at a time.
// Each applied event stays in effect for at least HOLD_CYCLES clocks, so the
// CPU scan cannot miss a fast press/release pair.
// Optional build macro: KBD_REPEAT_FILTER_EN drops typematic repeat presses
// before they reach the queue.
module kbd_matrix_queue #(
    parameter int COLS        = 15,
    parameter int ROWS        = 5,
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 100000,
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      ps2_key,
    input  logic [COL_W-1:0] column,
    output logic [ROWS-1:0]  row,
    output logic [8:0]       map_code,
    input  logic             map_valid,
    input  logic [COL_W-1:0] map_col,
    input  logic [ROW_W-1:0] map_row,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    output logic             busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int ENT_W  = 1 + COL_W + ROW_W;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state, state_nxt;
    logic               strobe_q;
    logic               evt, col_ok, row_ok, repeat_hit;
    logic               push_req, push, pop, drop;
    logic               fifo_empty, fifo_full;
    logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level_q, level_nxt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               hold_done;
    logic               vld_p1;
    logic [ENT_W-1:0]   ent_p1;
    logic               ent_press_p1;
    logic [COL_W-1:0]   ent_col_p1;
    logic [ROW_W-1:0]   ent_row_p1;
    logic [ROWS-1:0]    matrix [COLS];

    assign map_code   = {ps2_key[8], ps2_key[7:0]};
    assign evt        = ps2_key[10] ^ strobe_q;
    assign col_ok     = int'(map_col) < COLS;
    assign row_ok     = int'(map_row) < ROWS;
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign hold_done  = (hold_cnt == '0);

    assign push_req  = evt && map_valid && col_ok && row_ok && !repeat_hit;
    // A full queue still accepts when the head leaves in the same cycle.
    assign push      = push_req && (!fifo_full || pop);
    assign drop      = push_req && fifo_full && !pop;
    assign level_nxt = level_q + LVL_W'(push) - LVL_W'(pop);

`ifdef KBD_REPEAT_FILTER_EN
    // Pressed state as it will be once every queued event has been applied.
    logic [ROWS-1:0] shadow [COLS];

    // Flag a press whose target key is already (or about to be) held.
    always_comb begin
        repeat_hit = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (map_col == COL_W'(c) && map_row == ROW_W'(r) &&
                    ps2_key[9] && shadow[c][r]) begin
                    repeat_hit = 1'b1;
                end
            end
        end
    end

    // Track pressed state at push time so pending entries are accounted for.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < COLS; c++) shadow[c] <= '0;
        end else if (push) begin
            for (int c = 0; c < COLS; c++) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (map_col == COL_W'(c) && map_row == ROW_W'(r)) begin
                        shadow[c][r] <= ps2_key[9];
                    end
                end
            end
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    // Strobe copy; loading it during reset suppresses a spurious first event.
    always_ff @(posedge clk) begin
        strobe_q <= ps2_key[10];
    end

    // Queue storage; contents need no reset because level_q gates them.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {ps2_key[9], map_col, map_row};
    end

    // Queue pointers, level and the sticky/busy status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level_q <= level_nxt;
            if (drop) overflow <= 1'b1;
            busy <= (level_nxt != '0) || (state_nxt == HOLD);
        end
    end

    assign fifo_level = level_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state: stay in HOLD back-to-back while the queue has work.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!fifo_empty) state_nxt = HOLD;
            HOLD: if (hold_done && fifo_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: pop when idle, or right as the previous hold expires.
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !fifo_empty;
            HOLD:    pop = hold_done && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    // Hold timer: reloaded on every pop, counts down to zero in HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (pop) begin
            hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
        end else if (state == HOLD && !hold_done) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
        end
    end

    // Popped entry valid flag; one cycle between pop and matrix update.
    always_ff @(posedge clk) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= pop;
    end

    // Popped entry payload.
    always_ff @(posedge clk) begin
        if (pop) ent_p1 <= fifo_mem[rd_ptr];
    end

    assign {ent_press_p1, ent_col_p1, ent_row_p1} = ent_p1;

    // Key matrix: active-low, the last applied event for a bit wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < COLS; c++) matrix[c] <= '1;
        end else if (vld_p1) begin
            for (int c = 0; c < COLS; c++) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (ent_col_p1 == COL_W'(c) && ent_row_p1 == ROW_W'(r)) begin
                        matrix[c][r] <= ~ent_press_p1;
                    end
                end
            end
        end
    end

    // Column read; an out-of-range column reads as all keys released.
    always_comb begin
        row = '1;
        for (int c = 0; c < COLS; c++) begin
            if (column == COL_W'(c)) row = matrix[c];
        end
    end

endmodule

// File: tb/tb_kbd_matrix_queue.sv
// Bench for kbd_matrix_queue: instance A uses HOLD_CYCLES=4, instance B uses
// HOLD_CYCLES=20 so a 10-event burst sees exactly one pop.
module tb_kbd_matrix_queue;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic        rst_a, rst_b;
    logic [10:0] a_ps2, b_ps2;
    logic [3:0]  a_col, b_col, a_mc, b_mc;
    logic [4:0]  a_row, b_row;
    logic [8:0]  a_code, b_code;
    logic        a_mv, b_mv;
    logic [2:0]  a_mr, b_mr;
    logic [3:0]  a_lvl, b_lvl;
    logic        a_ovf, b_ovf, a_busy, b_busy;

    typedef struct { logic val; int when; } exp_t;
    exp_t sb[$];

    logic last_a, last_b;
    int   rb_a, rb_b;

    // Layout table: 0x15 -> (0,0), 0x1C -> (1,2), 0x66 unmapped,
    // anything else -> col = code[3:0], row = code[6:4].
    function automatic logic [7:0] map_fn(input logic [8:0] code);
        logic [7:0] r;
        r = {1'b1, code[3:0], code[6:4]};
        case (code[7:0])
            8'h15:   r = {1'b1, 4'd0, 3'd0};
            8'h1C:   r = {1'b1, 4'd1, 3'd2};
            8'h66:   r = 8'h00;
            default: ;
        endcase
        return r;
    endfunction

    assign {a_mv, a_mc, a_mr} = map_fn(a_code);
    assign {b_mv, b_mc, b_mr} = map_fn(b_code);

    kbd_matrix_queue #(.COLS(15), .ROWS(5), .FIFO_DEPTH(8), .HOLD_CYCLES(4)) u_a (
        .clk(clk), .reset(rst_a), .ps2_key(a_ps2), .column(a_col), .row(a_row),
        .map_code(a_code), .map_valid(a_mv), .map_col(a_mc), .map_row(a_mr),
        .fifo_level(a_lvl), .overflow(a_ovf), .busy(a_busy));

    kbd_matrix_queue #(.COLS(15), .ROWS(5), .FIFO_DEPTH(8), .HOLD_CYCLES(20)) u_b (
        .clk(clk), .reset(rst_b), .ps2_key(b_ps2), .column(b_col), .row(b_row),
        .map_code(b_code), .map_valid(b_mv), .map_col(b_mc), .map_row(b_mr),
        .fifo_level(b_lvl), .overflow(b_ovf), .busy(b_busy));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit inst, input logic [7:0] code, input logic pressed);
        if (inst) b_ps2 = {~b_ps2[10], pressed, 1'b0, code};
        else      a_ps2 = {~a_ps2[10], pressed, 1'b0, code};
    endtask

    task automatic arm(input bit inst, input int col, input int rb);
        if (inst) begin b_col = 4'(col); #1; rb_b = rb; last_b = b_row[rb]; end
        else      begin a_col = 4'(col); #1; rb_a = rb; last_a = a_row[rb]; end
    endtask

    task automatic tick_obs(input bit inst, output logic chg, output logic v);
        tick();
        v   = inst ? b_row[rb_b] : a_row[rb_a];
        chg = inst ? (v !== last_b) : (v !== last_a);
        if (inst) last_b = v; else last_a = v;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        a_ps2 = '0; b_ps2 = '0; a_col = '0; b_col = '0;
        tick(); tick();
        a_ps2[10] = 1'b1; b_ps2[10] = 1'b1;
        tick();
        rst_a = 1'b0; rst_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if ({a_lvl, a_busy, b_lvl, b_busy} !== 10'b0) begin
                n_err++;
                $display("FAIL reset_idle: lvl/busy A=%0d/%0b B=%0d/%0b want 0/0", a_lvl, a_busy, b_lvl, b_busy);
            end
        end
        n_cmp++;
        if ({a_ovf, b_ovf} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_overflow: got %0b%0b want 00", a_ovf, b_ovf);
        end
        for (int c = 0; c < 16; c++) begin
            a_col = 4'(c);
            tick();
            n_cmp++;
            if (a_row !== 5'h1f) begin
                n_err++;
                $display("FAIL reset_row col%0d: got %b want 11111", c, a_row);
            end
        end
        a_col = '0;
    endtask

    task automatic test_single_press();
        int t0, busy_n;
        logic chg, v;
        exp_t e;
        arm(0, 0, 0);
        send(0, 8'h15, 1'b1);
        t0 = cyc;
        sb.push_back('{1'b0, t0 + 3});
        busy_n = 0;
        for (int k = 1; k <= 10; k++) begin
            tick_obs(0, chg, v);
            if (a_busy) busy_n++;
            if (k == 1) begin
                n_cmp++;
                if (a_lvl !== 4'd1) begin n_err++; $display("FAIL single_lvl1: got %0d want 1", a_lvl); end
            end
            if (k == 2) begin
                n_cmp++;
                if (a_lvl !== 4'd0) begin n_err++; $display("FAIL single_lvl2: got %0d want 0", a_lvl); end
            end
            if (chg) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL single_apply: unexpected change to %0b at cycle %0d", v, cyc);
                end else begin
                    e = sb.pop_front();
                    if (v !== e.val || cyc != e.when) begin
                        n_err++; $display("FAIL single_apply: got %0b@%0d want %0b@%0d", v, cyc, e.val, e.when);
                    end
                end
            end
        end
        n_cmp++;
        if (busy_n != 5) begin n_err++; $display("FAIL single_busy_len: got %0d want 5", busy_n); end
        send(0, 8'h15, 1'b0);
        t0 = cyc;
        sb.push_back('{1'b1, t0 + 3});
        for (int k = 1; k <= 8; k++) begin
            tick_obs(0, chg, v);
            if (chg) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL single_release: unexpected change to %0b at cycle %0d", v, cyc);
                end else begin
                    e = sb.pop_front();
                    if (v !== e.val || cyc != e.when) begin
                        n_err++; $display("FAIL single_release: got %0b@%0d want %0b@%0d", v, cyc, e.val, e.when);
                    end
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL single_missing: %0d expected changes not seen, want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_press_release();
        int t0;
        logic chg, v;
        exp_t e;
        arm(0, 1, 2);
        send(0, 8'h1C, 1'b1);
        t0 = cyc;
        sb.push_back('{1'b0, t0 + 3});
        sb.push_back('{1'b1, t0 + 7});
        for (int k = 1; k <= 12; k++) begin
            tick_obs(0, chg, v);
            if (k == 1) send(0, 8'h1C, 1'b0);
            if (k == 2) begin
                n_cmp++;
                if (a_lvl !== 4'd1) begin n_err++; $display("FAIL pr_queued: got %0d want 1", a_lvl); end
            end
            if (chg) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL pr_apply: unexpected change to %0b at cycle %0d", v, cyc);
                end else begin
                    e = sb.pop_front();
                    if (v !== e.val || cyc != e.when) begin
                        n_err++; $display("FAIL pr_apply: got %0b@%0d want %0b@%0d", v, cyc, e.val, e.when);
                    end
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL pr_missing: %0d expected changes not seen, want 0", sb.size()); sb.delete(); end
        n_cmp++;
        if (a_row !== 5'h1f) begin n_err++; $display("FAIL pr_final: got %b want 11111", a_row); end
    endtask

    task automatic test_unmapped();
        logic [7:0] codes [3];
        codes[0] = 8'h66; codes[1] = 8'h0F; codes[2] = 8'h71;
        a_col = '0;
        tick();
        for (int i = 0; i < 3; i++) begin
            send(0, codes[i], 1'b1);
            for (int k = 0; k < 3; k++) begin
                tick();
                n_cmp++;
                if ({a_lvl, a_busy} !== 5'b0) begin
                    n_err++; $display("FAIL unmapped_%0h: lvl/busy %0d/%0b want 0/0", codes[i], a_lvl, a_busy);
                end
            end
        end
        n_cmp++;
        if (a_row !== 5'h1f) begin n_err++; $display("FAIL unmapped_row: got %b want 11111", a_row); end
        send(0, 8'h15, 1'b1);
        repeat (6) tick();
        n_cmp++;
        if (a_row !== 5'b11110) begin n_err++; $display("FAIL held_col0: got %b want 11110", a_row); end
        a_col = 4'd15;
        tick();
        n_cmp++;
        if (a_row !== 5'h1f) begin n_err++; $display("FAIL col15: got %b want 11111", a_row); end
        a_col = 4'd14;
        tick();
        n_cmp++;
        if (a_row !== 5'h1f) begin n_err++; $display("FAIL col14: got %b want 11111", a_row); end
        send(0, 8'h15, 1'b0);
        a_col = '0;
        repeat (8) tick();
        n_cmp++;
        if (a_row !== 5'h1f) begin n_err++; $display("FAIL unmapped_release: got %b want 11111", a_row); end
    endtask

    task automatic test_burst();
        int t0, peak;
        int lvl_exp [10] = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 8};
        logic chg, v;
        exp_t e;
        arm(1, 0, 0);
        send(1, 8'h15, 1'b1);
        t0 = cyc;
        for (int j = 1; j <= 9; j++) sb.push_back('{(j % 2 == 1) ? 1'b0 : 1'b1, t0 + 3 + 20 * (j - 1)});
        peak = 0;
        for (int k = 1; k <= 190; k++) begin
            tick_obs(1, chg, v);
            if (k <= 10) begin
                n_cmp++;
                if (b_lvl !== 4'(lvl_exp[k-1]) || b_ovf !== (k == 10)) begin
                    n_err++; $display("FAIL burst_k%0d: lvl/ovf %0d/%0b want %0d/%0b", k, b_lvl, b_ovf, lvl_exp[k-1], (k == 10));
                end
                if (int'(b_lvl) > peak) peak = int'(b_lvl);
                if (k < 10) send(1, 8'h15, ((k + 1) % 2 == 1));
            end
            if (chg) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL burst_apply: unexpected change to %0b at cycle %0d", v, cyc);
                end else begin
                    e = sb.pop_front();
                    if (v !== e.val || cyc != e.when) begin
                        n_err++; $display("FAIL burst_apply: got %0b@%0d want %0b@%0d", v, cyc, e.val, e.when);
                    end
                end
            end
        end
        n_cmp++;
        if (peak != 8) begin n_err++; $display("FAIL burst_peak: got %0d want 8", peak); end
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL burst_missing: %0d expected changes not seen, want 0", sb.size()); sb.delete(); end
        n_cmp++;
        if ({b_ovf, b_busy, b_row} !== {1'b1, 1'b0, 5'b11110}) begin
            n_err++; $display("FAIL burst_end: ovf/busy/row %0b/%0b/%b want 1/0/11110", b_ovf, b_busy, b_row);
        end
    endtask

    task automatic test_reset_midhold();
        b_col = 4'd1;
        send(1, 8'h1C, 1'b1); tick();
        send(1, 8'h1C, 1'b0); tick();
        send(1, 8'h1C, 1'b1); tick();
        send(1, 8'h1C, 1'b0); tick();
        n_cmp++;
        if ({b_lvl, b_busy, b_ovf, b_row} !== {4'd3, 1'b1, 1'b1, 5'b11011}) begin
            n_err++; $display("FAIL pre_reset: lvl/busy/ovf/row %0d/%0b/%0b/%b want 3/1/1/11011", b_lvl, b_busy, b_ovf, b_row);
        end
        rst_b = 1'b1;
        b_ps2[10] = ~b_ps2[10];
        tick();
        rst_b = 1'b0;
        n_cmp++;
        if ({b_lvl, b_busy, b_ovf, b_row} !== {4'd0, 1'b0, 1'b0, 5'h1f}) begin
            n_err++; $display("FAIL post_reset: lvl/busy/ovf/row %0d/%0b/%0b/%b want 0/0/0/11111", b_lvl, b_busy, b_ovf, b_row);
        end
        b_col = 4'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if ({b_lvl, b_busy, b_row} !== {4'd0, 1'b0, 5'h1f}) begin
                n_err++; $display("FAIL after_reset_k%0d: lvl/busy/row %0d/%0b/%b want 0/0/11111", k, b_lvl, b_busy, b_row);
            end
        end
    endtask

    task automatic test_repeat();
        a_col = 4'd1;
        send(0, 8'h1C, 1'b1);
        repeat (6) tick();
        n_cmp++;
        if (a_row !== 5'b11011) begin n_err++; $display("FAIL repeat_first: got %b want 11011", a_row); end
`ifdef KBD_REPEAT_FILTER_EN
        begin
            int t0;
            logic chg, v;
            exp_t e;
            for (int i = 0; i < 5; i++) begin
                send(0, 8'h1C, 1'b1);
                tick();
                n_cmp++;
                if ({a_lvl, a_busy, a_ovf} !== 6'b0) begin
                    n_err++; $display("FAIL repeat_filtered%0d: lvl/busy/ovf %0d/%0b/%0b want 0/0/0", i, a_lvl, a_busy, a_ovf);
                end
            end
            arm(0, 1, 2);
            send(0, 8'h1C, 1'b0);
            t0 = cyc;
            sb.push_back('{1'b1, t0 + 3});
            for (int k = 1; k <= 8; k++) begin
                tick_obs(0, chg, v);
                if (k == 1) begin
                    n_cmp++;
                    if (a_lvl !== 4'd1) begin n_err++; $display("FAIL repeat_release_lvl: got %0d want 1", a_lvl); end
                end
                if (chg) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_err++; $display("FAIL repeat_release: unexpected change to %0b at cycle %0d", v, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (v !== e.val || cyc != e.when) begin
                            n_err++; $display("FAIL repeat_release: got %0b@%0d want %0b@%0d", v, cyc, e.val, e.when);
                        end
                    end
                end
            end
            n_cmp++;
            if (sb.size() != 0) begin n_err++; $display("FAIL repeat_missing: %0d expected changes not seen, want 0", sb.size()); sb.delete(); end
        end
`else
        for (int i = 0; i < 5; i++) begin
            send(0, 8'h1C, 1'b1);
            tick();
        end
        n_cmp++;
        if (a_lvl !== 4'd4) begin n_err++; $display("FAIL repeat_queued: got %0d want 4", a_lvl); end
        repeat (20) tick();
        n_cmp++;
        if ({a_lvl, a_busy, a_row} !== {4'd0, 1'b0, 5'b11011}) begin
            n_err++; $display("FAIL repeat_drained: lvl/busy/row %0d/%0b/%b want 0/0/11011", a_lvl, a_busy, a_row);
        end
        send(0, 8'h1C, 1'b0);
        repeat (8) tick();
`endif
        n_cmp++;
        if (a_row !== 5'h1f) begin n_err++; $display("FAIL repeat_final: got %b want 11111", a_row); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_press_release();
        test_unmapped();
        test_burst();
        test_reset_midhold();
        test_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
